egr_tcu_tqu_pop_ctrl: RTL and testbench
=======================================

EGR_TCU_TQU_POP_CTRL -- requirements
Module: egr_tcu_tqu_pop_ctrl

Interface
REQ-001 SHALL have parameter N_Q, default 36, number of TQU queues.
REQ-002 SHALL have parameter DATA_W, default 64, width of the returned data word.
REQ-003 SHALL have parameter MAX_OUT, default 8 (range 1..16), maximum pops outstanding toward TQU.
REQ-004 SHALL have port cclk, input, 1, single block clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, enable for issuing new pops.
REQ-007 SHALL have port q_req, input, N_Q, TCU scheduler wants queue i.
REQ-008 SHALL have port q_ready, input, N_Q, TQU has data for queue i.
REQ-009 SHALL have port pop, output, N_Q, one-hot pop to TQU.
REQ-010 SHALL have port rd_valid, input, 1, TQU returned data word.
REQ-011 SHALL have port rd_data, input, DATA_W, returned data.
REQ-012 SHALL have port out_valid, output, 1, tagged data valid to TCU.
REQ-013 SHALL have port out_data, output, DATA_W, tagged data word.
REQ-014 SHALL have port out_qid, output, clog2(N_Q), source queue of out_data.
REQ-015 SHALL have port outstanding, output, clog2(MAX_OUT+1), pops not yet returned.
REQ-016 SHALL have port err_underflow, output, 1, sticky: data returned with no pop outstanding.

Function
REQ-017 SHALL compute eligible[i] = q_req[i] & q_ready[i] & en & ~pop[i] & (outstanding < MAX_OUT), masking a queue during the cycle its pop is asserted.
REQ-018 SHALL grant at most one eligible queue per cycle, round-robin: lowest index >= rr_ptr, else wrap to lowest index from 0.
REQ-019 SHALL advance rr_ptr to (grant+1) mod N_Q on grant; unchanged without grant; N_Q-1 wraps to 0.
REQ-020 SHALL register pop: grant in cycle t drives pop one-hot for exactly cycle t+1; all-zero otherwise.
REQ-021 SHALL push granted qid into in-order tag FIFO, depth MAX_OUT, in the grant cycle.
REQ-022 SHALL treat TQU returns as in pop order, at least 1 cycle after pop, no maximum latency.
REQ-023 SHALL, on rd_valid with FIFO non-empty, pop tag FIFO and drive out_valid/out_data/out_qid in the next cycle (latency 1), one cycle wide.
REQ-024 SHALL increment outstanding on grant, decrement on accepted rd_valid, hold on both or neither.
REQ-025 SHALL never exceed MAX_OUT; at outstanding == MAX_OUT, no grant even if a return occurs that cycle.
REQ-026 SHALL, on rd_valid with FIFO empty, set err_underflow, drop the word, leave outstanding at 0, out_valid low.
REQ-027 SHALL, with en low, issue no new grants while still accepting and tagging in-flight returns.
REQ-028 SHALL NOT backpressure out_valid; TCU always accepts.

Reset
REQ-029 SHALL asynchronously clear on rst_n low: pop=0, out_valid=0, out_data=0, out_qid=0, outstanding=0, err_underflow=0, rr_ptr=0, tag FIFO empty.
REQ-030 SHALL discard in-flight pops on reset mid-operation; returns after reset release with no new pop SHALL raise err_underflow.
REQ-031 SHALL issue no grant in the first cycle after rst_n deassertion.

Structure
REQ-032 SHALL place the egr_qid_t typedef, N_Q default, and MAX_OUT default in the shared egr package.
REQ-033 SHALL implement the round-robin arbiter as a sub-module egr_rr_arb, parametrised by N_Q.
REQ-034 SHALL implement the tag FIFO inline as a register array with read/write pointers wrapping at MAX_OUT.

Verification
REQ-035 SHALL verify round-robin with all 36 queues requesting and ready, en=1, rr_ptr=0 -> pops on queues 0,1,...,35,0 on consecutive cycles, provided returns keep outstanding < 8.
REQ-036 SHALL verify credit limit with MAX_OUT=8, no returns -> exactly 8 pops then pop=0, outstanding=8; one rd_valid -> outstanding 7, then one more pop.
REQ-037 SHALL verify tagging: pops to queues 5, 17, 3, then returns D0,D1,D2 -> out_qid 5,17,3 with matching data, each one cycle after its rd_valid.
REQ-038 SHALL verify underflow: rd_valid with outstanding=0 -> err_underflow=1 next cycle and sticky, out_valid=0.
REQ-039 SHALL verify simultaneous grant and return at outstanding=4 -> outstanding stays 4.
REQ-040 SHALL verify reset with 3 pops outstanding -> all outputs 0 asynchronously, rr_ptr=0, first post-reset grant to lowest eligible index.

Source files
------------

// File: rtl/egr_tcu_tqu_pop_ctrl_pkg.sv
// Shared egr types and defaults for the TQU pop controller.
package egr_tcu_tqu_pop_ctrl_pkg;

  localparam int unsigned NQDefault     = 36;
  localparam int unsigned MaxOutDefault = 8;
  localparam int unsigned DataWDefault  = 64;
  localparam int unsigned QidWDefault   = $clog2(NQDefault);

  typedef logic [QidWDefault-1:0] egr_qid_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/egr_tcu_tqu_pop_ctrl_if.sv
// TCU/TQU-facing signal bundle of the pop controller.
interface egr_tcu_tqu_pop_ctrl_if #(
  parameter int unsigned N_Q     = egr_tcu_tqu_pop_ctrl_pkg::NQDefault,
  parameter int unsigned DATA_W  = egr_tcu_tqu_pop_ctrl_pkg::DataWDefault,
  parameter int unsigned MAX_OUT = egr_tcu_tqu_pop_ctrl_pkg::MaxOutDefault
);
  import egr_tcu_tqu_pop_ctrl_pkg::*;

  localparam int unsigned QidW = clog2_min1(N_Q);
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic              en;
  logic [N_Q-1:0]    q_req;
  logic [N_Q-1:0]    q_ready;
  logic [N_Q-1:0]    pop;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [QidW-1:0]   out_qid;
  logic [CntW-1:0]   outstanding;
  logic              err_underflow;

  modport master (
    input  en, q_req, q_ready, rd_valid, rd_data,
    output pop, out_valid, out_data, out_qid, outstanding, err_underflow
  );

  modport slave (
    output en, q_req, q_ready, rd_valid, rd_data,
    input  pop, out_valid, out_data, out_qid, outstanding, err_underflow
  );

endinterface

// File: rtl/egr_tcu_tqu_pop_ctrl_rr_arb.sv
// Round-robin arbiter: lowest requester at or above the pointer, else wrap from 0.
module egr_rr_arb
  import egr_tcu_tqu_pop_ctrl_pkg::*;
#(
  parameter  int unsigned N_Q  = NQDefault,
  localparam int unsigned IdxW = clog2_min1(N_Q)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_Q-1:0]  req_i,
  output logic [N_Q-1:0]  gnt_o,
  output logic            gnt_valid_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     j;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    j           = 0;
    for (int unsigned i = 0; i < N_Q; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N_Q) j = j - N_Q;
      if (!gnt_valid_o && req_i[IdxW'(j)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(j);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (gnt_idx_o == IdxW'(N_Q - 1)) ? '0 : gnt_idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/egr_tcu_tqu_pop_ctrl.sv
// Issues credit-limited round-robin pops to the TQU and tags in-order returns with their qid.
module egr_tcu_tqu_pop_ctrl
  import egr_tcu_tqu_pop_ctrl_pkg::*;
#(
  parameter int unsigned N_Q     = NQDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned MAX_OUT = MaxOutDefault
) (
  input  logic                   cclk,
  input  logic                   rst_n,
  egr_tcu_tqu_pop_ctrl_if.master bus
);

  localparam int unsigned QidW = clog2_min1(N_Q);
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam int unsigned PtrW = clog2_min1(MAX_OUT);

  logic              armed_q;
  logic [N_Q-1:0]    pop_q, pop_d, eligible;
  logic              gnt_valid;
  logic [QidW-1:0]   gnt_idx;
  logic [CntW-1:0]   outs_q, outs_d;
  logic [QidW-1:0]   tag_mem_q [MAX_OUT];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              credit_ok, fifo_empty, accept, underflow;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [QidW-1:0]   out_qid_q, out_qid_d;
  logic              err_q;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUT - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // The FIFO occupancy is exactly the outstanding count, so no separate fill level is kept.
  assign credit_ok  = outs_q < CntW'(MAX_OUT);
  assign fifo_empty = (outs_q == '0);
  assign accept     = bus.rd_valid & ~fifo_empty;
  assign underflow  = bus.rd_valid & fifo_empty;

  // armed_q suppresses a grant on the first edge after reset release.
  assign eligible = bus.q_req & bus.q_ready & ~pop_q &
                    {N_Q{bus.en & credit_ok & armed_q}};

  egr_rr_arb #(
    .N_Q(N_Q)
  ) u_arb (
    .clk_i      (cclk),
    .rst_ni     (rst_n),
    .req_i      (eligible),
    .gnt_o      (pop_d),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  always_comb begin
    outs_d     = outs_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;
    out_qid_d  = out_qid_q;
    if (gnt_valid) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (accept) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      out_data_d = bus.rd_data;
      out_qid_d  = tag_mem_q[rd_ptr_q];
    end
    case ({gnt_valid, accept})
      2'b10:   outs_d = outs_q + CntW'(1);
      2'b01:   outs_d = outs_q - CntW'(1);
      default: outs_d = outs_q;
    endcase
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      pop_q       <= '0;
      outs_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_qid_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      pop_q       <= pop_d;
      outs_q      <= outs_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= accept;
      out_data_q  <= out_data_d;
      out_qid_q   <= out_qid_d;
      err_q       <= err_q | underflow;
    end
  end

  // Tag storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge cclk) begin
    if (gnt_valid) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign bus.pop           = pop_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_qid       = out_qid_q;
  assign bus.outstanding   = outs_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_egr_tcu_tqu_pop_ctrl.sv
// Scoreboard bench for egr_tcu_tqu_pop_ctrl: queue-based reference model plus an independent monitor.
module tb_egr_tcu_tqu_pop_ctrl;

  localparam int NQ = 36;
  localparam int DW = 64;
  localparam int MO = 8;

  logic cclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 cclk = ~cclk;

  egr_tcu_tqu_pop_ctrl_if #(.N_Q(NQ), .DATA_W(DW), .MAX_OUT(MO)) bus ();

  egr_tcu_tqu_pop_ctrl #(
    .N_Q    (NQ),
    .DATA_W (DW),
    .MAX_OUT(MO)
  ) dut (
    .cclk (cclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {int pop_idx; int outs; bit err; bit ov;} st_t;
  typedef struct {logic [DW-1:0] d; int qid;} out_t;
  typedef struct {int qid; int e;} tag_t;

  st_t  exp_st[$];
  out_t exp_out[$];
  tag_t tags[$];
  int   m_rr, m_outs, m_popidx, edge_cnt;
  bit   m_err, m_armed, in_reset;
  int   checks = 0;
  int   errors = 0;
  st_t  st;
  out_t ob;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [NQ-1:0] rvec(int pct);
    logic [NQ-1:0] v;
    for (int i = 0; i < NQ; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  function automatic logic [NQ-1:0] oh(int i);
    logic [NQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // A return is legal only in a cycle strictly after the oldest pop was shown to the TQU.
  function automatic bit can_ret();
    return tags.size() > 0 && tags[0].e + 2 <= edge_cnt;
  endfunction

  task automatic model_edge(bit e, logic [NQ-1:0] rq, logic [NQ-1:0] rdy, bit rv,
                            logic [DW-1:0] d);
    int   g;
    bit   acc;
    tag_t t;
    out_t o;
    st_t  s;
    g   = -1;
    acc = rv && tags.size() > 0;
    if (rv && !acc) m_err = 1'b1;
    if (m_armed && e && m_outs < MO) begin
      for (int k = 0; k < NQ; k++) begin
        int i;
        i = (m_rr + k) % NQ;
        if (g < 0 && rq[i] && rdy[i] && i != m_popidx) g = i;
      end
    end
    if (acc) begin
      t     = tags.pop_front();
      o.d   = d;
      o.qid = t.qid;
      exp_out.push_back(o);
      m_outs--;
    end
    if (g >= 0) begin
      t.qid = g;
      t.e   = edge_cnt;
      tags.push_back(t);
      m_rr = (g + 1) % NQ;
      m_outs++;
    end
    m_popidx = g;
    m_armed  = 1'b1;
    edge_cnt++;
    s = '{g, m_outs, m_err, acc};
    exp_st.push_back(s);
  endtask

  task automatic step(bit e, logic [NQ-1:0] rq, logic [NQ-1:0] rdy, bit rv, logic [DW-1:0] d);
    bus.en       = e;
    bus.q_req    = rq;
    bus.q_ready  = rdy;
    bus.rd_valid = rv;
    bus.rd_data  = d;
    @(posedge cclk);
    #1;
    model_edge(e, rq, rdy, rv, d);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && tags.size() > 0; c++) step(1'b0, '0, '0, can_ret(), rnd64());
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Entered at posedge+1; asserts reset between edges so clearing must be asynchronous.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("rst_pop", 64'(bus.pop), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_qid", 64'(bus.out_qid), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst_err", 64'(bus.err_underflow), 64'd0);
    exp_st.delete();
    exp_out.delete();
    tags.delete();
    m_rr = 0; m_outs = 0; m_popidx = -1; m_err = 1'b0; m_armed = 1'b0;
    bus.en = 1'b0; bus.q_req = '0; bus.q_ready = '0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    @(posedge cclk);
    @(posedge cclk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  always @(negedge cclk) begin
    if (!in_reset && exp_st.size() > 0) begin
      logic [NQ-1:0] ev;
      st = exp_st.pop_front();
      ev = '0;
      if (st.pop_idx >= 0) ev[st.pop_idx] = 1'b1;
      chk("pop", 64'(bus.pop), 64'(ev));
      chk("outstanding", 64'(bus.outstanding), 64'(st.outs));
      chk("err_underflow", 64'(bus.err_underflow), 64'(st.err));
      chk("out_valid", 64'(bus.out_valid), 64'(st.ov));
      if (bus.out_valid) begin
        if (exp_out.size() == 0) begin
          chk("out_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          ob = exp_out.pop_front();
          chk("out_data", bus.out_data, ob.d);
          chk("out_qid", 64'(bus.out_qid), 64'(ob.qid));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    in_reset = 1'b1;
    edge_cnt = 0;
    m_popidx = -1;
    bus.en = 1'b0; bus.q_req = '0; bus.q_ready = '0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    @(posedge cclk);
    #1;
    do_reset();

    // Full round-robin sweep with returns keeping credit available.
    for (int c = 0; c < 40; c++) step(1'b1, '1, '1, can_ret(), rnd64());
    drain();

    // Credit limit: saturate, one return frees exactly one more pop.
    for (int c = 0; c < 12; c++) step(1'b1, '1, '1, 1'b0, '0);
    step(1'b1, '1, '1, 1'b1, rnd64());
    for (int c = 0; c < 3; c++) step(1'b1, '1, '1, 1'b0, '0);
    drain();

    // Tagging order 5, 17, 3.
    step(1'b1, oh(5), '1, 1'b0, '0);
    step(1'b1, oh(17), '1, 1'b0, '0);
    step(1'b1, oh(3), '1, 1'b0, '0);
    drain();

    // Grant and return in the same cycle at outstanding 4.
    for (int c = 0; c < 4; c++) step(1'b1, '1, '1, 1'b0, '0);
    step(1'b1, '1, '1, 1'b1, rnd64());
    drain();

    // Underflow and stickiness.
    step(1'b0, '0, '0, 1'b1, rnd64());
    for (int c = 0; c < 3; c++) step(1'b1, '0, '1, 1'b0, '0);

    // Reset with three pops in flight, then a stale return.
    for (int c = 0; c < 3; c++) step(1'b1, '1, '1, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0);
    do_reset();
    step(1'b0, '0, '0, 1'b1, rnd64());
    step(1'b0, '0, '0, 1'b0, '0);
    do_reset();
    step(1'b1, oh(7) | oh(20), '1, 1'b0, '0);
    step(1'b1, oh(7) | oh(20), '1, 1'b0, '0);
    step(1'b1, oh(7) | oh(20), '1, 1'b0, '0);
    drain();

    // Randomized traffic, including en low with returns in flight.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 7) != 0, rvec(40), rvec(60),
           can_ret() && ($urandom_range(0, 2) != 0), rnd64());
    end
    drain();

    repeat (3) @(posedge cclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
